// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters (A = control unit,
// B = address/branch unit). Round-robin arbitration in IDLE, operands
// latched at acceptance and held on the ALU for a fixed EXEC window
// (SLOW_LAT cycles for mul/div/rem, one cycle otherwise). Result and
// flags are registered and returned on one response channel tagged with
// the requester id. Divide/remainder by zero and opcode 4'b1111 never
// reach EXEC; they answer immediately with rsp_err=1.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   a_* / b_*                       request ports (valid/ready, operands, op, shamt)
//   alu_data1/2, alu_aluOp/shamt    operands driven to the ALU
//   alu_result/zero/negative        ALU outputs
//   rsp_valid/ready/id/aluOut/zero/negative/err   response channel
//
// state | meaning
// ------+--------------------------------------------
// IDLE  | no request in flight, readies may assert
// EXEC  | operands held on the ALU, down-counter runs
// RESP  | response held until rsp_ready

module alu_arbiter #(
  parameter int WIDTH    = 32,
  parameter int SLOW_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data1,
  input  logic [WIDTH-1:0] a_data2,
  input  logic [3:0]       a_aluOp,
  input  logic [4:0]       a_shamt,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data1,
  input  logic [WIDTH-1:0] b_data2,
  input  logic [3:0]       b_aluOp,
  input  logic [4:0]       b_shamt,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [3:0]       alu_aluOp,
  output logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_negative,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_aluOut,
  output logic             rsp_zero,
  output logic             rsp_negative,
  output logic             rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] SLOW_CNT = 4'(SLOW_LAT - 1);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;   // 0 = A, 1 = B
  logic [3:0]       cnt_q, cnt_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] op_data1_q, op_data1_d;
  logic [WIDTH-1:0] op_data2_q, op_data2_d;
  logic [3:0]       op_alu_op_q, op_alu_op_d;
  logic [4:0]       op_shamt_q, op_shamt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_alu_out_q, rsp_alu_out_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_negative_q, rsp_negative_d;
  logic             rsp_err_q, rsp_err_d;

  logic             grant_a, grant_b, accept;
  logic [WIDTH-1:0] sel_data1, sel_data2;
  logic [3:0]       sel_op;
  logic [4:0]       sel_shamt;
  logic             sel_slow, sel_err;

  // On a tie the port that did not win last time gets the grant.
  assign grant_a = (state_q == IDLE) && a_valid && (!b_valid || last_grant_q);
  assign grant_b = (state_q == IDLE) && b_valid && (!a_valid || !last_grant_q);
  assign accept  = grant_a || grant_b;

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  assign sel_data1 = grant_b ? b_data1 : a_data1;
  assign sel_data2 = grant_b ? b_data2 : a_data2;
  assign sel_op    = grant_b ? b_aluOp : a_aluOp;
  assign sel_shamt = grant_b ? b_shamt : a_shamt;

  assign sel_slow = (sel_op == 4'b1100) || (sel_op == 4'b1101) || (sel_op == 4'b1110);
  assign sel_err  = (sel_op == 4'b1111) ||
                    (((sel_op == 4'b1101) || (sel_op == 4'b1110)) && (sel_data2 == '0));

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    cnt_d          = cnt_q;
    id_d           = id_q;
    op_data1_d     = op_data1_q;
    op_data2_d     = op_data2_q;
    op_alu_op_d    = op_alu_op_q;
    op_shamt_d     = op_shamt_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_alu_out_d  = rsp_alu_out_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_negative_d = rsp_negative_q;
    rsp_err_d      = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // Rejected requests still load the operand registers.
          op_data1_d   = sel_data1;
          op_data2_d   = sel_data2;
          op_alu_op_d  = sel_op;
          op_shamt_d   = sel_shamt;
          id_d         = grant_b;
          last_grant_d = grant_b;
          if (sel_err) begin
            state_d        = RESP;
            rsp_valid_d    = 1'b1;
            rsp_id_d       = grant_b;
            rsp_alu_out_d  = '0;
            rsp_zero_d     = 1'b0;
            rsp_negative_d = 1'b0;
            rsp_err_d      = 1'b1;
          end else begin
            state_d = EXEC;
            cnt_d   = sel_slow ? SLOW_CNT : 4'd0;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d        = RESP;
          rsp_valid_d    = 1'b1;
          rsp_id_d       = id_q;
          rsp_alu_out_d  = alu_result;
          rsp_zero_d     = alu_zero;
          rsp_negative_d = alu_negative;
          rsp_err_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      cnt_q          <= '0;
      id_q           <= 1'b0;
      op_data1_q     <= '0;
      op_data2_q     <= '0;
      op_alu_op_q    <= '0;
      op_shamt_q     <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_alu_out_q  <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_negative_q <= 1'b0;
      rsp_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
      id_q           <= id_d;
      op_data1_q     <= op_data1_d;
      op_data2_q     <= op_data2_d;
      op_alu_op_q    <= op_alu_op_d;
      op_shamt_q     <= op_shamt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_alu_out_q  <= rsp_alu_out_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_negative_q <= rsp_negative_d;
      rsp_err_q      <= rsp_err_d;
    end
  end

  assign alu_data1    = op_data1_q;
  assign alu_data2    = op_data2_q;
  assign alu_aluOp    = op_alu_op_q;
  assign alu_shamt    = op_shamt_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_aluOut   = rsp_alu_out_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_negative = rsp_negative_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [31:0] a_data1, a_data2, b_data1, b_data2;
  logic [3:0]  a_aluOp, b_aluOp;
  logic [4:0]  a_shamt, b_shamt;
  logic [31:0] alu_data1, alu_data2, alu_result;
  logic [3:0]  alu_aluOp;
  logic [4:0]  alu_shamt;
  logic        alu_zero, alu_negative;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_negative, rsp_err;
  logic [31:0] rsp_aluOut;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .SLOW_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_data1(a_data1), .a_data2(a_data2),
    .a_aluOp(a_aluOp), .a_shamt(a_shamt),
    .b_valid(b_valid), .b_ready(b_ready), .b_data1(b_data1), .b_data2(b_data2),
    .b_aluOp(b_aluOp), .b_shamt(b_shamt),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_aluOp(alu_aluOp),
    .alu_shamt(alu_shamt), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_negative(alu_negative),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_aluOut(rsp_aluOut), .rsp_zero(rsp_zero), .rsp_negative(rsp_negative),
    .rsp_err(rsp_err)
  );

  // Simple ALU stand-in.
  always_comb begin
    case (alu_aluOp)
      4'b0001: alu_result = alu_data1 + alu_data2;
      4'b0010: alu_result = alu_data1 - alu_data2;
      4'b1100: alu_result = alu_data1 * alu_data2;
      4'b1101: alu_result = (alu_data2 != 0) ? alu_data1 / alu_data2 : 32'd0;
      4'b1110: alu_result = (alu_data2 != 0) ? alu_data1 % alu_data2 : 32'd0;
      default: alu_result = alu_data1 & alu_data2;
    endcase
    alu_zero     = (alu_result == 32'd0);
    alu_negative = alu_result[31];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rsp_valid"},    32'(rsp_valid), 0);
    check({tag, ".rsp_id"},       32'(rsp_id), 0);
    check({tag, ".rsp_aluOut"},   rsp_aluOut, 0);
    check({tag, ".rsp_zero"},     32'(rsp_zero), 0);
    check({tag, ".rsp_negative"}, 32'(rsp_negative), 0);
    check({tag, ".rsp_err"},      32'(rsp_err), 0);
    check({tag, ".alu_data1"},    alu_data1, 0);
    check({tag, ".alu_data2"},    alu_data2, 0);
    check({tag, ".alu_aluOp"},    32'(alu_aluOp), 0);
    check({tag, ".alu_shamt"},    32'(alu_shamt), 0);
  endtask

  task automatic idle_cycles(input int n);
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    rsp_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int  acc_cyc[$];
  bit  acc_id[$];
  bit  q_rsp_id[$];
  int  q_rsp_val[$];
  int  exp_cyc[4] = '{0, 3, 6, 9};
  bit  exp_id[4]  = '{0, 1, 0, 1};
  int  exp_val[4] = '{3, 30, 9, 4};
  int  a_n, b_n;
  bit  seen_rsp;

  initial begin
    reset = 1'b1;
    a_valid = 0; a_data1 = 0; a_data2 = 0; a_aluOp = 0; a_shamt = 0;
    b_valid = 0; b_data1 = 0; b_data2 = 0; b_aluOp = 0; b_shamt = 0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("reset");

    // Contention: both ports hold two fast ops each.
    @(negedge clk);
    a_valid = 1; a_data1 = 1;  a_data2 = 2;  a_aluOp = 4'b0001;
    b_valid = 1; b_data1 = 10; b_data2 = 20; b_aluOp = 4'b0001;
    a_n = 0; b_n = 0;
    for (int c = 0; c < 13; c++) begin
      #1;
      if (a_valid && a_ready) begin acc_cyc.push_back(c); acc_id.push_back(0); a_n++; end
      if (b_valid && b_ready) begin acc_cyc.push_back(c); acc_id.push_back(1); b_n++; end
      if (rsp_valid && rsp_ready) begin q_rsp_id.push_back(rsp_id); q_rsp_val.push_back(int'(rsp_aluOut)); end
      @(negedge clk);
      if (a_n == 1) begin a_data1 = 4; a_data2 = 5; end
      if (a_n == 2) a_valid = 0;
      if (b_n == 1) begin b_data1 = 7; b_data2 = 3; b_aluOp = 4'b0010; end
      if (b_n == 2) b_valid = 0;
    end
    check("cont.n_accept", acc_cyc.size(), 4);
    check("cont.n_rsp", q_rsp_id.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < acc_cyc.size()) begin
        check($sformatf("cont.acc_cyc%0d", i), acc_cyc[i], exp_cyc[i]);
        check($sformatf("cont.acc_id%0d", i), 32'(acc_id[i]), 32'(exp_id[i]));
      end
      if (i < q_rsp_id.size()) begin
        check($sformatf("cont.rsp_id%0d", i), 32'(q_rsp_id[i]), 32'(exp_id[i]));
        check($sformatf("cont.rsp_val%0d", i), q_rsp_val[i], exp_val[i]);
      end
    end
    idle_cycles(3);

    // Single fast request on A.
    a_valid = 1; a_data1 = 5; a_data2 = 7; a_aluOp = 4'b0001; rsp_ready = 1;
    #1;
    check("single.a_ready", 32'(a_ready), 1);
    check("single.b_ready", 32'(b_ready), 0);
    @(negedge clk); a_valid = 0; #1;
    check("single.c1_valid", 32'(rsp_valid), 0);
    @(negedge clk); #1;
    check("single.rsp_valid", 32'(rsp_valid), 1);
    check("single.rsp_id", 32'(rsp_id), 0);
    check("single.rsp_aluOut", rsp_aluOut, 12);
    check("single.rsp_zero", 32'(rsp_zero), 0);
    check("single.rsp_err", 32'(rsp_err), 0);
    @(negedge clk); #1;
    check("single.c3_valid", 32'(rsp_valid), 0);
    idle_cycles(2);

    // Slow multiply on B.
    b_valid = 1; b_data1 = 6; b_data2 = 7; b_aluOp = 4'b1100; b_shamt = 5'd3;
    #1;
    check("slow.b_ready", 32'(b_ready), 1);
    @(negedge clk); b_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check($sformatf("slow.c%0d_d1", k), alu_data1, 6);
      check($sformatf("slow.c%0d_d2", k), alu_data2, 7);
      check($sformatf("slow.c%0d_op", k), 32'(alu_aluOp), 32'hC);
      check($sformatf("slow.c%0d_shamt", k), 32'(alu_shamt), 3);
      check($sformatf("slow.c%0d_valid", k), 32'(rsp_valid), 0);
      @(negedge clk);
    end
    #1;
    check("slow.rsp_valid", 32'(rsp_valid), 1);
    check("slow.rsp_aluOut", rsp_aluOut, 42);
    check("slow.rsp_id", 32'(rsp_id), 1);
    idle_cycles(3);

    // Error screening: divide by zero, then opcode 1111.
    for (int e = 0; e < 2; e++) begin
      a_valid = 1;
      a_data1 = (e == 0) ? 9 : 3;
      a_data2 = (e == 0) ? 0 : 4;
      a_aluOp = (e == 0) ? 4'b1101 : 4'b1111;
      #1;
      check($sformatf("err%0d.a_ready", e), 32'(a_ready), 1);
      @(negedge clk); a_valid = 0; #1;
      check($sformatf("err%0d.rsp_valid", e), 32'(rsp_valid), 1);
      check($sformatf("err%0d.rsp_err", e), 32'(rsp_err), 1);
      check($sformatf("err%0d.rsp_aluOut", e), rsp_aluOut, 0);
      check($sformatf("err%0d.rsp_zero", e), 32'(rsp_zero), 0);
      check($sformatf("err%0d.rsp_id", e), 32'(rsp_id), 0);
      check($sformatf("err%0d.alu_op", e), 32'(alu_aluOp), (e == 0) ? 32'hD : 32'hF);
      @(negedge clk); #1;
      check($sformatf("err%0d.c2_valid", e), 32'(rsp_valid), 0);
      idle_cycles(2);
    end

    // Backpressure with B waiting.
    a_valid = 1; a_data1 = 2; a_data2 = 3; a_aluOp = 4'b0001; rsp_ready = 0;
    #1;
    check("bp.a_ready", 32'(a_ready), 1);
    @(negedge clk);
    a_valid = 0;
    b_valid = 1; b_data1 = 8; b_data2 = 9; b_aluOp = 4'b0001;
    #1;
    check("bp.c1_b_ready", 32'(b_ready), 0);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk); #1;
      check($sformatf("bp.c%0d_valid", k), 32'(rsp_valid), 1);
      check($sformatf("bp.c%0d_aluOut", k), rsp_aluOut, 5);
      check($sformatf("bp.c%0d_id", k), 32'(rsp_id), 0);
      check($sformatf("bp.c%0d_err", k), 32'(rsp_err), 0);
      check($sformatf("bp.c%0d_b_ready", k), 32'(b_ready), 0);
    end
    @(negedge clk); rsp_ready = 1; #1;
    check("bp.c7_valid", 32'(rsp_valid), 1);
    check("bp.c7_b_ready", 32'(b_ready), 0);
    @(negedge clk); #1;
    check("bp.c8_b_ready", 32'(b_ready), 1);
    check("bp.c8_valid", 32'(rsp_valid), 0);
    @(negedge clk); b_valid = 0;
    @(negedge clk); #1;
    check("bp.b_rsp_valid", 32'(rsp_valid), 1);
    check("bp.b_rsp_aluOut", rsp_aluOut, 17);
    check("bp.b_rsp_id", 32'(rsp_id), 1);
    idle_cycles(3);

    // Reset during EXEC of a slow op.
    a_valid = 1; a_data1 = 3; a_data2 = 3; a_aluOp = 4'b1100; a_shamt = 5'd9;
    #1;
    check("rst.a_ready", 32'(a_ready), 1);
    @(negedge clk); a_valid = 0;
    @(negedge clk); #1;
    check("rst.exec_op", 32'(alu_aluOp), 32'hC);
    reset = 1;
    @(negedge clk); reset = 0; #1;
    check_reset_outputs("rst");
    seen_rsp = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (rsp_valid) seen_rsp = 1;
    end
    check("rst.no_rsp", 32'(seen_rsp), 0);
    a_valid = 1; a_data1 = 1; a_data2 = 1; a_aluOp = 4'b0001;
    b_valid = 1; b_data1 = 2; b_data2 = 2; b_aluOp = 4'b0001;
    #1;
    check("rst.tie_a_ready", 32'(a_ready), 1);
    check("rst.tie_b_ready", 32'(b_ready), 0);
    idle_cycles(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU between two requesters, port A (control unit) and port B (address/branch unit).
- Arbitrates with round-robin, latches the operands of the granted request and drives them to the ALU for a fixed number of cycles. Slow ops (multiply, divide, remainder) get a multicycle window.
- Registers the result and flags, and returns them on one shared response channel tagged with the requester id.
- Screens out divide-by-zero and the unused opcode 4'b1111 before they reach the ALU.

Parameters:
- WIDTH, 32, operand/result width.
- SLOW_LAT, 4, EXEC cycles for opcodes 4'b1100/4'b1101/4'b1110. Legal range 1..15.

Ports:
- clk  in  1  single clock; everything on rising edge
- reset  in  1  synchronous, active-high
- a_valid  in  1  port A request valid
- a_ready  out  1  port A request accepted this cycle
- a_data1, a_data2  in  WIDTH  port A operands
- a_aluOp  in  4  port A opcode (ALU encoding)
- a_shamt  in  5  port A shift amount
- b_valid, b_ready, b_data1, b_data2, b_aluOp, b_shamt  same as port A, for port B
- alu_data1, alu_data2  out  WIDTH  operands to ALU
- alu_aluOp  out  4  opcode to ALU
- alu_shamt  out  5  shift amount to ALU
- alu_result  in  WIDTH  ALU aluOut
- alu_zero, alu_negative  in  1  ALU flags
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  0 = port A, 1 = port B
- rsp_aluOut  out  WIDTH  registered result
- rsp_zero, rsp_negative  out  1  registered flags
- rsp_err  out  1  request rejected (divide/remainder by zero, or opcode 4'b1111)

Behaviour:
- FSM states:
  - IDLE: no request in flight.
  - EXEC: operands held on the ALU; a down-counter runs.
  - RESP: response held until accepted.
- Reset (synchronous):
  - state=IDLE, last_grant=B (so A wins the first tie).
  - rsp_valid=0, rsp_id=0, rsp_aluOut=0, rsp_zero=0, rsp_negative=0, rsp_err=0.
  - Operand registers cleared, so alu_data1/alu_data2/alu_aluOp/alu_shamt=0.
  - Counter=0.
  - An op in flight when reset asserts is dropped; no response is produced for it.
- Ready signals:
  - a_ready/b_ready are combinational.
  - They can be 1 only in IDLE, and at most one is 1 per cycle.
  - Both are 0 in EXEC and RESP.
- Grant rules, in IDLE:
  - Only one valid: that port is granted.
  - Both valid: grant the port that is not last_grant.
  - The grant updates last_grant.
- Acceptance edge:
  - Latch data1, data2, aluOp and shamt into the operand registers; the ALU outputs come straight from these registers.
  - Latch the granted id.
- Error screening at acceptance:
  - Error if aluOp=4'b1111, or aluOp is 4'b1101/4'b1110 with data2==0.
  - On error, go to RESP next cycle with rsp_err=1, rsp_aluOut=0, rsp_zero=0, rsp_negative=0.
  - The operand registers are still loaded with the rejected request.
- Normal request: go to EXEC.
  - Counter = SLOW_LAT-1 for 4'b1100/4'b1101/4'b1110; otherwise counter = 0.
- EXEC:
  - Operands stay stable on the ALU for the whole state.
  - Decrement the counter each cycle.
  - On the cycle the counter reads 0, capture alu_result/alu_zero/alu_negative into the rsp registers, set rsp_err=0, and go to RESP.
- RESP:
  - rsp_valid=1.
  - All rsp_* outputs hold stable until rsp_ready=1.
  - On that handshake edge: rsp_valid←0, go to IDLE.
  - Requests that are valid during RESP wait; they are not accepted until IDLE.
- Latency, accept at cycle t:
  - Fast op: rsp_valid rises at t+2.
  - Slow op: rsp_valid rises at t+1+SLOW_LAT.
  - Error: rsp_valid rises at t+1.
  - With rsp_ready held at 1, a fast op occupies 3 cycles, so the next accept is at t+3.
- Request-side rules:
  - A request not accepted must keep its valid high and its fields stable.
  - The arbiter never depends on a request field after the acceptance edge.
- No internal width arithmetic beyond the 4-bit counter; results pass through unmodified.

Test Plan:
- Single request: a_valid=1, op 4'b0001, data1=5, data2=7, rsp_ready=1.
  - a_ready=1 at cycle 0.
  - At cycle 2: rsp_valid=1, rsp_id=0, rsp_aluOut=12, rsp_zero=0, rsp_err=0.
- Contention: a_valid and b_valid both held for 2 ops each, fast ops, rsp_ready=1.
  - Grant order A, B, A, B.
  - Accepts at cycles 0, 3, 6, 9.
  - rsp_id sequence 0, 1, 0, 1.
- Slow op with SLOW_LAT=4: b op 4'b1100, 6×7.
  - alu_* stable for 4 EXEC cycles.
  - rsp_valid at cycle 5, rsp_aluOut=42, rsp_id=1.
- Error screening:
  - a op 4'b1101 with data2=0 → rsp_valid at cycle 1, rsp_err=1, rsp_aluOut=0.
  - Opcode 4'b1111 → same response.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid, with b_valid=1 throughout.
  - rsp_* stable for all 5 cycles; b_ready=0 throughout.
  - B is accepted the cycle after the handshake.
- Reset mid-op: assert reset during EXEC of a slow op.
  - Next cycle: all outputs at reset values.
  - No response is ever produced for the dropped op.
  - First tie after reset goes to A.
